// File: rtl/accum_sweep_ctrl.sv
// Step sweep sequencer for the step-input accumulator: drives clear/enable/step.
// Optional ACCUM_SWEEP_CONTINUOUS_EN: restart the sweep at its end instead of finishing.
module accum_sweep_ctrl #(
  parameter int STEP_BIT  = 5,
  parameter int DWELL_BIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [STEP_BIT-1:0]  k_start,
  input  logic [STEP_BIT-1:0]  k_stop,
  input  logic [STEP_BIT-1:0]  k_inc,
  input  logic [DWELL_BIT-1:0] dwell,
  output logic                 acc_clr,
  output logic                 acc_en,
  output logic [STEP_BIT-1:0]  acc_k,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  // Control handshake: start/abort are level-sampled on each rising clk edge;
  // start is accepted only in IDLE with abort low, abort is honoured in every other state.
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t               state, state_n;
  logic [STEP_BIT-1:0]  sh_k_start, sh_k_start_n;
  logic [STEP_BIT-1:0]  sh_k_stop, sh_k_stop_n;
  logic [STEP_BIT-1:0]  sh_k_inc, sh_k_inc_n;
  logic [DWELL_BIT-1:0] sh_dwell, sh_dwell_n;
  logic [STEP_BIT-1:0]  cur_k, cur_k_n;
  logic [DWELL_BIT-1:0] dwell_cnt, dwell_cnt_n;
  logic                 acc_clr_n, acc_en_n, busy_n, done_n;
  logic [STEP_BIT-1:0]  acc_k_n;
  logic [STEP_BIT:0]    nxt;
  logic                 last_step;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sh_k_start <= '0;
      sh_k_stop  <= '0;
      sh_k_inc   <= '0;
      sh_dwell   <= '0;
      cur_k      <= '0;
      dwell_cnt  <= '0;
      acc_clr    <= 1'b0;
      acc_en     <= 1'b0;
      acc_k      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      sh_k_start <= sh_k_start_n;
      sh_k_stop  <= sh_k_stop_n;
      sh_k_inc   <= sh_k_inc_n;
      sh_dwell   <= sh_dwell_n;
      cur_k      <= cur_k_n;
      dwell_cnt  <= dwell_cnt_n;
      acc_clr    <= acc_clr_n;
      acc_en     <= acc_en_n;
      acc_k      <= acc_k_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n      = state;
    sh_k_start_n = sh_k_start;
    sh_k_stop_n  = sh_k_stop;
    sh_k_inc_n   = sh_k_inc;
    sh_dwell_n   = sh_dwell;
    cur_k_n      = cur_k;
    dwell_cnt_n  = dwell_cnt;
    acc_clr_n    = 1'b0;
    acc_en_n     = 1'b0;
    acc_k_n      = acc_k;
    busy_n       = 1'b0;
    done_n       = 1'b0;
    // One extra bit so a step past the top of the range counts as overshoot.
    nxt          = {1'b0, cur_k} + {1'b0, sh_k_inc};
    last_step    = (sh_k_inc == '0) || (nxt > {1'b0, sh_k_stop});

    if (state != IDLE && abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            sh_k_start_n = k_start;
            sh_k_stop_n  = k_stop;
            sh_k_inc_n   = k_inc;
            sh_dwell_n   = dwell;
            state_n      = CLEAR;
            acc_clr_n    = 1'b1;
            busy_n       = 1'b1;
          end
        end
        CLEAR: begin
          cur_k_n     = sh_k_start;
          dwell_cnt_n = '0;
          state_n     = RUN;
          acc_en_n    = 1'b1;
          acc_k_n     = sh_k_start;
          busy_n      = 1'b1;
        end
        RUN: begin
          acc_en_n = 1'b1;
          busy_n   = 1'b1;
          if (dwell_cnt == sh_dwell) begin
            dwell_cnt_n = '0;
            if (last_step) begin
`ifdef ACCUM_SWEEP_CONTINUOUS_EN
              cur_k_n = sh_k_start;
              acc_k_n = sh_k_start;
              done_n  = 1'b1;
`else
              state_n  = DONE;
              acc_en_n = 1'b0;
              busy_n   = 1'b0;
              done_n   = 1'b1;
`endif
            end else begin
              cur_k_n = nxt[STEP_BIT-1:0];
              acc_k_n = nxt[STEP_BIT-1:0];
            end
          end else begin
            dwell_cnt_n = dwell_cnt + {{(DWELL_BIT-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_sweep_ctrl.sv
// Directed self-checking bench for accum_sweep_ctrl with a behavioural accumulator.
// Continuous-mode checks run when ACCUM_SWEEP_CONTINUOUS_EN is defined.
module tb_accum_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [4:0] k_start, k_stop, k_inc;
  logic [7:0] dwell;
  logic       acc_clr, acc_en, busy, done;
  logic [4:0] acc_k;
  logic [1:0] state_dbg;
  logic [15:0] acc;

  int n_chk  = 0;
  int n_pass = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  accum_sweep_ctrl #(.STEP_BIT(5), .DWELL_BIT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .k_start(k_start), .k_stop(k_stop), .k_inc(k_inc), .dwell(dwell),
    .acc_clr(acc_clr), .acc_en(acc_en), .acc_k(acc_k),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // Accumulator the sequencer drives: cnt <= cnt + k when enabled.
  always @(posedge clk) begin
    if (acc_clr) acc <= 16'd0;
    else if (acc_en) acc <= acc + {11'd0, acc_k};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [4:0] ks, input logic [4:0] kst,
                         input logic [4:0] ki, input logic [7:0] dw);
    k_start = ks; k_stop = kst; k_inc = ki; dwell = dw;
  endtask

  // Launches a sweep, then walks exp_q one enabled cycle at a time.
  // poke >= 0 pulses start (with a different config) during that RUN cycle.
  task automatic run_sweep(input string name, input logic [4:0] ks, input logic [4:0] kst,
                           input logic [4:0] ki, input logic [7:0] dw,
                           input logic [15:0] acc_exp, input int poke);
    logic [4:0] ek;
    int i;
    set_cfg(ks, kst, ki, dw);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_cfg(5'd17, 5'd31, 5'd1, 8'd0);
    check({name, "_clr"}, acc_clr, 1);
    check({name, "_clr_busy"}, busy, 1);
    check({name, "_clr_en"}, acc_en, 0);
    i = 0;
    while (exp_q.size() > 0) begin
      ek = exp_q.pop_front();
      tick();
      start = 1'b0;
      check({name, "_en"}, acc_en, 1);
      check({name, "_k"}, acc_k, ek);
      check({name, "_nodone"}, done, 0);
      if (i == poke) start = 1'b1;
      i++;
    end
    tick();
    start = 1'b0;
    check({name, "_done"}, done, 1);
    check({name, "_done_busy"}, busy, 0);
    check({name, "_done_en"}, acc_en, 0);
    check({name, "_acc"}, acc, acc_exp);
    tick();
    check({name, "_pulse"}, done, 0);
    check({name, "_idle"}, state_dbg, 0);
  endtask

  task automatic push_basic();
    exp_q = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd4, 5'd4, 5'd4, 5'd4, 5'd6, 5'd6, 5'd6, 5'd6};
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    set_cfg(5'd0, 5'd0, 5'd0, 8'd0);
    tick();
    tick();
    check("rst_clr", acc_clr, 0);
    check("rst_en", acc_en, 0);
    check("rst_k", acc_k, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    tick();

`ifdef ACCUM_SWEEP_CONTINUOUS_EN
    begin
      logic [4:0] seq [12];
      seq = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd4, 5'd4, 5'd4, 5'd4, 5'd6, 5'd6, 5'd6, 5'd6};
      set_cfg(5'd2, 5'd6, 5'd2, 8'd3);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("cont_clr", acc_clr, 1);
      for (int c = 1; c <= 30; c++) begin
        tick();
        check("cont_en", acc_en, 1);
        check("cont_k", acc_k, seq[(c - 1) % 12]);
        check("cont_done", done, (c == 13 || c == 25) ? 1 : 0);
        check("cont_busy", busy, 1);
      end
      // 30 enabled cycles: two full sweeps (96) + four at 2 + two at 4.
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("cont_abort_en", acc_en, 0);
      check("cont_abort_busy", busy, 0);
      check("cont_abort_done", done, 0);
      check("cont_acc", acc, 112);
      tick();
      check("cont_idle", state_dbg, 0);
    end
`else
    // Basic sweep.
    push_basic();
    run_sweep("basic", 5'd2, 5'd6, 5'd2, 8'd3, 16'd48, -1);

    // Carry out of the 5-bit step: 30 + 5 = 35 > 31.
    exp_q = '{5'd30};
    run_sweep("carry", 5'd30, 5'd31, 5'd5, 8'd0, 16'd30, -1);

    // Zero increment: one step, dwell+1 = 2 cycles.
    exp_q = '{5'd7, 5'd7};
    run_sweep("inc0", 5'd7, 5'd20, 5'd0, 8'd1, 16'd14, -1);

    // Start above stop: single step at k_start.
    exp_q = '{5'd9};
    run_sweep("inverted", 5'd9, 5'd3, 5'd1, 8'd0, 16'd9, -1);

    // Start pulsed during RUN is ignored.
    push_basic();
    run_sweep("busy_start", 5'd2, 5'd6, 5'd2, 8'd3, 16'd48, 4);

    // Abort on the third RUN cycle.
    set_cfg(5'd2, 5'd6, 5'd2, 8'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_pre_en", acc_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_en", acc_en, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_k", acc_k, 2);
    check("abort_acc", acc, 6);
    tick();
    check("abort_nodone", done, 0);
    check("abort_hold", acc, 6);

    // start+abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_clr", acc_clr, 0);
    check("sa_busy", busy, 0);
    check("sa_state", state_dbg, 0);

    // Reset held 3 cycles mid-sweep.
    set_cfg(5'd2, 5'd6, 5'd2, 8'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    check("mrst_en", acc_en, 0);
    check("mrst_k", acc_k, 0);
    check("mrst_busy", busy, 0);
    check("mrst_state", state_dbg, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("mrst_idle", busy, 0);
    push_basic();
    run_sweep("after_rst", 5'd2, 5'd6, 5'd2, 8'd3, 16'd48, -1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
